// File: rtl/tx_uart_module_pkg.sv
// Shared UART definitions: frame state encodings, default baud divider and data width.
// Used by both the transmit and receive paths.
package tx_uart_module_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_state_e;

  localparam int UART_CLK_DIV_DEF = 5208;  // 50 MHz / 9600 baud
  localparam int UART_DATA_W      = 8;

endpackage

// File: rtl/tx_bps_module.sv
// Baud tick generator: counts 0..CLK_DIV-1 while Count_Sig is high and
// pulses BPS_CLK for one cycle on the last count of each bit.
module tx_bps_module
  import tx_uart_module_pkg::*;
#(
  parameter int CLK_DIV = UART_CLK_DIV_DEF
) (
  input  logic CLK,
  input  logic RSTn,
  input  logic Count_Sig,
  output logic BPS_CLK
);

  localparam int CNT_W = $clog2(CLK_DIV);

  logic [CNT_W-1:0] cnt;

  assign BPS_CLK = Count_Sig && (cnt == CNT_W'(CLK_DIV - 1));

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      cnt <= '0;
    end else if (!Count_Sig || BPS_CLK) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/tx_uart_module.sv
// UART transmitter: one byte per valid/ready handshake, LSB first, optional
// parity, 1 or 2 stop bits, registered serial output and a done strobe per frame.
module tx_uart_module
  import tx_uart_module_pkg::*;
#(
  parameter int CLK_DIV    = UART_CLK_DIV_DEF,
  parameter bit PARITY_EN  = 1'b0,
  parameter bit PARITY_ODD = 1'b0,
  parameter int STOP_BITS  = 1
) (
  input  logic                   CLK,
  input  logic                   RSTn,
  input  logic                   TX_Valid,
  input  logic [UART_DATA_W-1:0] TX_Data,
  output logic                   TX_Ready,
  output logic                   TX_Done_Sig,
  output logic                   TX_Pin_Out
);

  localparam int IDX_W = $clog2(UART_DATA_W);

  uart_state_e            state, state_nxt;
  logic                   bps_tick;
  logic [UART_DATA_W-1:0] shift_reg;
  logic [IDX_W-1:0]       bit_idx;
  logic                   stop_cnt;
  logic                   parity_bit;
  logic                   pin_nxt, done_nxt;
  logic                   load, shift_en, stop_adv, stop_clr;

  assign TX_Ready = (state == ST_IDLE);

  tx_bps_module #(.CLK_DIV(CLK_DIV)) u_bps (
    .CLK       (CLK),
    .RSTn      (RSTn),
    .Count_Sig (state != ST_IDLE),
    .BPS_CLK   (bps_tick)
  );

  always_comb begin
    state_nxt = state;
    pin_nxt   = TX_Pin_Out;
    done_nxt  = 1'b0;
    load      = 1'b0;
    shift_en  = 1'b0;
    stop_adv  = 1'b0;
    stop_clr  = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (TX_Valid) begin
          state_nxt = ST_START;
          pin_nxt   = 1'b0;
          load      = 1'b1;
        end
      end
      ST_START: begin
        if (bps_tick) begin
          state_nxt = ST_DATA;
          pin_nxt   = shift_reg[0];
        end
      end
      ST_DATA: begin
        if (bps_tick) begin
          shift_en = 1'b1;
          if (bit_idx == IDX_W'(UART_DATA_W - 1)) begin
            state_nxt = PARITY_EN ? ST_PARITY : ST_STOP;
            pin_nxt   = PARITY_EN ? parity_bit : 1'b1;
          end else begin
            // shift_reg advances on this same edge, so the next bit is [1]
            pin_nxt = shift_reg[1];
          end
        end
      end
      ST_PARITY: begin
        if (bps_tick) begin
          state_nxt = ST_STOP;
          pin_nxt   = 1'b1;
        end
      end
      ST_STOP: begin
        if (bps_tick) begin
          if (stop_cnt == 1'(STOP_BITS - 1)) begin
            state_nxt = ST_IDLE;
            done_nxt  = 1'b1;
            stop_clr  = 1'b1;
          end else begin
            stop_adv = 1'b1;
          end
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        pin_nxt   = 1'b1;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state       <= ST_IDLE;
      TX_Pin_Out  <= 1'b1;
      TX_Done_Sig <= 1'b0;
      bit_idx     <= '0;
      stop_cnt    <= 1'b0;
    end else begin
      state       <= state_nxt;
      TX_Pin_Out  <= pin_nxt;
      TX_Done_Sig <= done_nxt;
      if (load) begin
        bit_idx <= '0;
      end else if (shift_en) begin
        bit_idx <= bit_idx + 1'b1;
      end
      if (stop_clr) begin
        stop_cnt <= 1'b0;
      end else if (stop_adv) begin
        stop_cnt <= stop_cnt + 1'b1;
      end
    end
  end

  // Payload registers carry no reset; they are only consumed after a load.
  always_ff @(posedge CLK) begin
    if (load) begin
      shift_reg  <= TX_Data;
      parity_bit <= (^TX_Data) ^ PARITY_ODD;
    end else if (shift_en) begin
      shift_reg <= {1'b0, shift_reg[UART_DATA_W-1:1]};
    end
  end

endmodule

// File: tb/tb_tx_uart_module.sv
// Bench for tx_uart_module: four configurations checked cycle by cycle against
// an expected frame built from the byte, parity and stop-bit rules.
module tb_tx_uart_module;

  logic       CLK = 1'b0;
  logic       RSTn;
  logic       valid [4];
  logic [7:0] data  [4];
  logic       pin   [4];
  logic       rdy   [4];
  logic       done  [4];

  int div  [4] = '{4, 4, 4, 5208};
  bit pen  [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
  bit podd [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
  int stp  [4] = '{1, 1, 2, 1};

  int total = 0;
  int bad   = 0;

  always #5 CLK = ~CLK;

  tx_uart_module #(.CLK_DIV(4)) u0 (
    .CLK(CLK), .RSTn(RSTn), .TX_Valid(valid[0]), .TX_Data(data[0]),
    .TX_Ready(rdy[0]), .TX_Done_Sig(done[0]), .TX_Pin_Out(pin[0]));
  tx_uart_module #(.CLK_DIV(4), .PARITY_EN(1'b1)) u1 (
    .CLK(CLK), .RSTn(RSTn), .TX_Valid(valid[1]), .TX_Data(data[1]),
    .TX_Ready(rdy[1]), .TX_Done_Sig(done[1]), .TX_Pin_Out(pin[1]));
  tx_uart_module #(.CLK_DIV(4), .PARITY_EN(1'b1), .PARITY_ODD(1'b1), .STOP_BITS(2)) u2 (
    .CLK(CLK), .RSTn(RSTn), .TX_Valid(valid[2]), .TX_Data(data[2]),
    .TX_Ready(rdy[2]), .TX_Done_Sig(done[2]), .TX_Pin_Out(pin[2]));
  tx_uart_module u3 (
    .CLK(CLK), .RSTn(RSTn), .TX_Valid(valid[3]), .TX_Data(data[3]),
    .TX_Ready(rdy[3]), .TX_Done_Sig(done[3]), .TX_Pin_Out(pin[3]));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Sends one byte on instance u starting at a falling edge. keep leaves
  // TX_Valid high for a back-to-back follow-up; poke pulses TX_Valid mid-frame.
  task automatic send(input int u, input logic [7:0] b, input bit keep, input bit poke);
    logic       bits[$];
    int         f;
    int         errs = 0, rlow = 0, dearly = 0, lowrun = 0, explow = 0;
    bit         inlow = 1'b1;
    logic [7:0] dec = '0;
    logic       par_s = 1'b0;
    int         m;
    bits.push_back(1'b0);
    for (int k = 0; k < 8; k++) bits.push_back(b[k]);
    if (pen[u]) bits.push_back((^b) ^ podd[u]);
    for (int s = 0; s < stp[u]; s++) bits.push_back(1'b1);
    f = bits.size() * div[u];
    for (int i = 0; i < bits.size(); i++) begin
      if (bits[i]) break;
      explow += div[u];
    end

    valid[u] = 1'b1;
    data[u]  = b;
    chk("ready_pre", rdy[u], 1);
    @(posedge CLK);
    @(negedge CLK);
    if (!keep) valid[u] = 1'b0;
    for (int j = 0; j < f; j++) begin
      m = j / div[u];
      if (pin[u] !== bits[m]) errs++;
      if (rdy[u] === 1'b0) rlow++;
      if (done[u] !== 1'b0) dearly++;
      if (inlow && pin[u] === 1'b0) lowrun++;
      else inlow = 1'b0;
      if (j % div[u] == div[u] / 2) begin
        if (m >= 1 && m <= 8) dec[m-1] = pin[u];
        if (m == 9) par_s = pin[u];
      end
      data[u] = 8'($urandom);
      if (poke && !keep && j == f / 2)     valid[u] = 1'b1;
      if (poke && !keep && j == f / 2 + 1) valid[u] = 1'b0;
      @(negedge CLK);
    end
    chk("line", errs, 0);
    chk("ready_low", rlow, f);
    chk("done_early", dearly, 0);
    chk("low_run", lowrun, explow);
    chk("byte", dec, b);
    if (pen[u]) chk("parity", par_s, (^b) ^ podd[u]);
    chk("done_end", done[u], 1);
    chk("ready_end", rdy[u], 1);
    chk("idle_pin", pin[u], 1);
    if (!keep) begin
      @(negedge CLK);
      chk("done_clear", done[u], 0);
    end
  endtask

  initial begin
    for (int u = 0; u < 4; u++) begin
      valid[u] = 1'b0;
      data[u]  = '0;
    end
    RSTn = 1'b0;
    repeat (3) @(negedge CLK);
    for (int u = 0; u < 4; u++) begin
      chk("rst_pin", pin[u], 1);
      chk("rst_ready", rdy[u], 1);
      chk("rst_done", done[u], 0);
    end
    RSTn = 1'b1;
    @(negedge CLK);

    send(0, 8'h55, 1'b0, 1'b0);
    send(1, 8'h07, 1'b0, 1'b0);
    send(2, 8'h07, 1'b0, 1'b0);
    send(0, 8'hA5, 1'b1, 1'b0);
    send(0, 8'h3C, 1'b0, 1'b0);
    send(0, 8'h96, 1'b0, 1'b1);

    // Abort a frame while the line is low in the data bits.
    valid[0] = 1'b1;
    data[0]  = 8'h00;
    @(posedge CLK);
    @(negedge CLK);
    valid[0] = 1'b0;
    repeat (16) @(negedge CLK);
    #2 RSTn = 1'b0;
    #1;
    chk("abort_pin", pin[0], 1);
    chk("abort_ready", rdy[0], 1);
    chk("abort_done", done[0], 0);
    repeat (3) begin
      @(negedge CLK);
      chk("abort_done_hold", done[0], 0);
    end
    RSTn = 1'b1;
    @(negedge CLK);
    chk("post_rst_pin", pin[0], 1);
    send(0, 8'h81, 1'b0, 1'b0);

    for (int i = 0; i < 24; i++) begin
      int u;
      bit keep;
      u    = $urandom_range(0, 2);
      keep = 1'($urandom_range(0, 1));
      send(u, 8'($urandom), keep, 1'($urandom_range(0, 1)));
      if (keep) send(u, 8'($urandom), 1'b0, 1'b0);
    end

    send(3, 8'h00, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
